logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 105 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester arbiter in front of a shared logic unit
module logic_unit_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        req0Valid,
  input  logic        req1Valid,
  input  logic [2:0]  req0Control,
  input  logic [2:0]  req1Control,
  input  logic [31:0] req0OperantA,
  input  logic [31:0] req0OperantB,
  input  logic [31:0] req1OperantA,
  input  logic [31:0] req1OperantB,
  output logic        req0Ready,
  output logic        req1Ready,
  output logic        rsp0Valid,
  output logic        rsp1Valid,
  input  logic        rsp0Ready,
  input  logic        rsp1Ready,
  output logic [31:0] rspResult,
  output logic [2:0]  luControl,
  output logic [31:0] luOperantA,
  output logic [31:0] luOperantB,
  input  logic [31:0] luResult
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        owner_id;
  logic        grant_id;
  logic [2:0]  ctl_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;

  // Grant selection and same-cycle accept handshake; readies only in IDLE and out of reset
  always_comb begin
    grant_id = 1'b0;
    if (req0Valid && req1Valid) begin
      grant_id = FIXED_PRIORITY ? 1'b0 : ~last_grant;
    end else begin
      grant_id = req1Valid;
    end
    req0Ready = nReset && (state == IDLE) && req0Valid && !grant_id;
    req1Ready = nReset && (state == IDLE) && req1Valid && grant_id;
  end

  assign luControl  = ctl_q;
  assign luOperantA = opa_q;
  assign luOperantB = opb_q;

  // Operation sequencer: capture request, run the shared unit for one cycle, hold the result
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_id   <= 1'b0;
      ctl_q      <= 3'd0;
      opa_q      <= 32'd0;
      opb_q      <= 32'd0;
      rspResult  <= 32'd0;
      rsp0Valid  <= 1'b0;
      rsp1Valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0Valid || req1Valid) begin
            ctl_q      <= grant_id ? req1Control  : req0Control;
            opa_q      <= grant_id ? req1OperantA : req0OperantA;
            opb_q      <= grant_id ? req1OperantB : req0OperantB;
            owner_id   <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rspResult <= luResult;
          rsp0Valid <= !owner_id;
          rsp1Valid <= owner_id;
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's ready can complete the handshake
          if ((rsp0Valid && rsp0Ready) || (rsp1Valid && rsp1Ready)) begin
            rsp0Valid <= 1'b0;
            rsp1Valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp0Valid <= 1'b0;
          rsp1Valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  logic        clock;
  logic        nReset;
  logic        req0Valid, req1Valid;
  logic [2:0]  req0Control, req1Control;
  logic [31:0] req0OperantA, req0OperantB, req1OperantA, req1OperantB;
  logic        rsp0Ready, rsp1Ready;

  logic        req0Ready, req1Ready, rsp0Valid, rsp1Valid;
  logic [31:0] rspResult, luOperantA, luOperantB, luResult;
  logic [2:0]  luControl;

  logic        fp_req0Ready, fp_req1Ready, fp_rsp0Valid, fp_rsp1Valid;
  logic [31:0] fp_rspResult, fp_luOperantA, fp_luOperantB, fp_luResult;
  logic [2:0]  fp_luControl;

  int checks = 0;
  int fails  = 0;

  function automatic logic [31:0] lu_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000: lu_model = a;
      3'b001: lu_model = a & b;
      3'b010: lu_model = a | b;
      3'b011: lu_model = a ^ b;
      3'b100: lu_model = {{16{a[15]}}, a[15:0]};
      3'b101: lu_model = {{24{a[7]}}, a[7:0]};
      3'b110: lu_model = {16'd0, a[15:0]};
      default: lu_model = {24'd0, a[7:0]};
    endcase
  endfunction

  assign luResult    = lu_model(luControl, luOperantA, luOperantB);
  assign fp_luResult = lu_model(fp_luControl, fp_luOperantA, fp_luOperantB);

  logic_unit_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clock(clock), .nReset(nReset),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Control(req0Control), .req1Control(req1Control),
    .req0OperantA(req0OperantA), .req0OperantB(req0OperantB),
    .req1OperantA(req1OperantA), .req1OperantB(req1OperantB),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .rsp0Valid(rsp0Valid), .rsp1Valid(rsp1Valid),
    .rsp0Ready(rsp0Ready), .rsp1Ready(rsp1Ready),
    .rspResult(rspResult), .luControl(luControl),
    .luOperantA(luOperantA), .luOperantB(luOperantB), .luResult(luResult)
  );

  logic_unit_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clock(clock), .nReset(nReset),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Control(req0Control), .req1Control(req1Control),
    .req0OperantA(req0OperantA), .req0OperantB(req0OperantB),
    .req1OperantA(req1OperantA), .req1OperantB(req1OperantB),
    .req0Ready(fp_req0Ready), .req1Ready(fp_req1Ready),
    .rsp0Valid(fp_rsp0Valid), .rsp1Valid(fp_rsp1Valid),
    .rsp0Ready(rsp0Ready), .rsp1Ready(rsp1Ready),
    .rspResult(fp_rspResult), .luControl(fp_luControl),
    .luOperantA(fp_luOperantA), .luOperantB(fp_luOperantB), .luResult(fp_luResult)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    req0Valid = 0; req1Valid = 0; req0Control = 0; req1Control = 0;
    req0OperantA = 0; req0OperantB = 0; req1OperantA = 0; req1OperantB = 0;
    rsp0Ready = 0; rsp1Ready = 0;
  endtask

  task automatic do_reset();
    nReset = 0;
    clear_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    nReset = 1;
  endtask

  task automatic test_reset();
    nReset = 0;
    clear_inputs();
    req0Valid = 1; req1Valid = 1;
    repeat (2) @(posedge clock);
    #2;
    checks++; if (req0Ready !== 1'b0) begin fails++; $display("FAIL reset_req0Ready: got %b want 0", req0Ready); end
    checks++; if (req1Ready !== 1'b0) begin fails++; $display("FAIL reset_req1Ready: got %b want 0", req1Ready); end
    checks++; if ({rsp0Valid, rsp1Valid} !== 2'b00) begin fails++; $display("FAIL reset_rspValid: got %b want 00", {rsp0Valid, rsp1Valid}); end
    checks++; if (rspResult !== 32'd0) begin fails++; $display("FAIL reset_rspResult: got %h want 0", rspResult); end
    checks++; if ({luControl, luOperantA, luOperantB} !== 67'd0) begin fails++; $display("FAIL reset_lu: got %h %h %h want 0", luControl, luOperantA, luOperantB); end
    @(negedge clock);
    nReset = 1;
    #1;
    checks++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin fails++; $display("FAIL reset_first_tie: got %b%b want 10", req0Ready, req1Ready); end
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    req0Valid = 1; req0Control = 3'b010; req0OperantA = 32'h0000F0F0; req0OperantB = 32'h00FF00FF;
    #1;
    checks++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin fails++; $display("FAIL single_accept: got %b%b want 10", req0Ready, req1Ready); end
    cyc();
    req0Valid = 0;
    #1;
    checks++; if (luControl !== 3'b010 || luOperantA !== 32'h0000F0F0 || luOperantB !== 32'h00FF00FF) begin fails++; $display("FAIL single_lu: got %b %h %h want 010 0000f0f0 00ff00ff", luControl, luOperantA, luOperantB); end
    checks++; if (rsp0Valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", rsp0Valid); end
    cyc();
    checks++; if (rsp0Valid !== 1'b1 || rsp1Valid !== 1'b0) begin fails++; $display("FAIL single_rspValid: got %b%b want 10", rsp0Valid, rsp1Valid); end
    checks++; if (rspResult !== 32'h00FFF0FF) begin fails++; $display("FAIL single_result: got %h want 00fff0ff", rspResult); end
    rsp0Ready = 1;
    cyc();
    rsp0Ready = 0;
    checks++; if (rsp0Valid !== 1'b0) begin fails++; $display("FAIL single_done: got %b want 0", rsp0Valid); end
    checks++; if (luOperantA !== 32'h0000F0F0) begin fails++; $display("FAIL single_lu_hold: got %h want 0000f0f0", luOperantA); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp;
    do_reset();
    req0Valid = 1; req0Control = 3'b001; req0OperantA = 32'h12345678; req0OperantB = 32'h0F0F0F0F;
    req1Valid = 1; req1Control = 3'b011; req1OperantA = 32'hFFFF0000; req1OperantB = 32'h0F0F0F0F;
    rsp0Ready = 1; rsp1Ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 32'h02040608 : 32'hF0F00F0F;
      #1;
      checks++; if (req0Ready !== (i % 2 == 0) || req1Ready !== (i % 2 == 1)) begin fails++; $display("FAIL rr_grant%0d: got %b%b", i, req0Ready, req1Ready); end
      cyc();
      checks++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin fails++; $display("FAIL rr_exec_ready%0d: got %b%b want 00", i, req0Ready, req1Ready); end
      cyc();
      checks++; if (rsp0Valid !== (i % 2 == 0) || rsp1Valid !== (i % 2 == 1)) begin fails++; $display("FAIL rr_rspValid%0d: got %b%b", i, rsp0Valid, rsp1Valid); end
      checks++; if (rspResult !== exp) begin fails++; $display("FAIL rr_result%0d: got %h want %h", i, rspResult, exp); end
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req0Valid = 1; req0Control = 3'b001; req0OperantA = 32'h12345678; req0OperantB = 32'h0F0F0F0F;
    req1Valid = 1; req1Control = 3'b011; req1OperantA = 32'hFFFF0000; req1OperantB = 32'h0F0F0F0F;
    rsp0Ready = 1; rsp1Ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fp_req0Ready !== 1'b1 || fp_req1Ready !== 1'b0) begin fails++; $display("FAIL fp_grant%0d: got %b%b want 10", i, fp_req0Ready, fp_req1Ready); end
      cyc();
      checks++; if (fp_req1Ready !== 1'b0) begin fails++; $display("FAIL fp_exec_req1Ready%0d: got %b want 0", i, fp_req1Ready); end
      cyc();
      checks++; if (fp_rsp0Valid !== 1'b1 || fp_rsp1Valid !== 1'b0 || fp_rspResult !== 32'h02040608) begin fails++; $display("FAIL fp_rsp%0d: got %b%b %h want 10 02040608", i, fp_rsp0Valid, fp_rsp1Valid, fp_rspResult); end
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_back_pressure();
    do_reset();
    req1Valid = 1; req1Control = 3'b101; req1OperantA = 32'h00000080; req1OperantB = 32'h0;
    #1;
    checks++; if (req1Ready !== 1'b1) begin fails++; $display("FAIL bp_accept: got %b want 1", req1Ready); end
    cyc();
    req1Valid = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      req0Valid = 1;
      rsp0Ready = (i % 2 == 0);
      #1;
      checks++; if (rsp1Valid !== 1'b1 || rsp0Valid !== 1'b0 || rspResult !== 32'hFFFFFF80) begin fails++; $display("FAIL bp_hold%0d: got %b%b %h want 01 ffffff80", i, rsp0Valid, rsp1Valid, rspResult); end
      checks++; if (req0Ready !== 1'b0) begin fails++; $display("FAIL bp_req0Ready%0d: got %b want 0", i, req0Ready); end
      cyc();
    end
    req0Valid = 0; rsp0Ready = 0; rsp1Ready = 1;
    #1;
    checks++; if (rsp1Valid !== 1'b1) begin fails++; $display("FAIL bp_before_hs: got %b want 1", rsp1Valid); end
    cyc();
    rsp1Ready = 0;
    checks++; if (rsp1Valid !== 1'b0) begin fails++; $display("FAIL bp_after_hs: got %b want 0", rsp1Valid); end
    req0Valid = 1;
    #1;
    checks++; if (req0Ready !== 1'b1) begin fails++; $display("FAIL bp_idle_again: got %b want 1", req0Ready); end
    req0Valid = 0;
    cyc();
    cyc();
    rsp0Ready = 1;
    cyc();
    clear_inputs();
  endtask

  task automatic test_ops();
    logic [2:0]  ctl [5] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
    logic [31:0] opa [5] = '{32'h00008001, 32'h0000007F, 32'hABCDEF12, 32'hABCDEF12, 32'hDEADBEEF};
    logic [31:0] exp [5] = '{32'hFFFF8001, 32'h0000007F, 32'h0000EF12, 32'h00000012, 32'hDEADBEEF};
    do_reset();
    rsp0Ready = 1;
    for (int i = 0; i < 5; i++) begin
      req0Valid = 1; req0Control = ctl[i]; req0OperantA = opa[i]; req0OperantB = 32'h12345678;
      cyc();
      req0Valid = 0;
      cyc();
      checks++; if (rsp0Valid !== 1'b1 || rspResult !== exp[i]) begin fails++; $display("FAIL op%0d: got %b %h want 1 %h", i, rsp0Valid, rspResult, exp[i]); end
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_reset_abort();
    do_reset();
    req1Valid = 1; req1Control = 3'b011; req1OperantA = 32'hFFFF0000; req1OperantB = 32'h0F0F0F0F;
    cyc();
    req1Valid = 0;
    #1;
    checks++; if (luControl !== 3'b011) begin fails++; $display("FAIL abort_exec_lu: got %b want 011", luControl); end
    nReset = 0;
    #1;
    checks++; if ({luControl, luOperantA, luOperantB} !== 67'd0 || rspResult !== 32'd0) begin fails++; $display("FAIL abort_async: got %b %h %h %h want zeros", luControl, luOperantA, luOperantB, rspResult); end
    checks++; if ({rsp0Valid, rsp1Valid, req0Ready, req1Ready} !== 4'b0000) begin fails++; $display("FAIL abort_flags: got %b want 0000", {rsp0Valid, rsp1Valid, req0Ready, req1Ready}); end
    @(posedge clock);
    @(negedge clock);
    nReset = 1;
    rsp1Ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if ({rsp0Valid, rsp1Valid} !== 2'b00) begin fails++; $display("FAIL abort_no_rsp%0d: got %b want 00", i, {rsp0Valid, rsp1Valid}); end
    end
    rsp1Ready = 0;
    req0Valid = 1; req0Control = 3'b010; req0OperantA = 32'h0000F0F0; req0OperantB = 32'h00FF00FF;
    cyc();
    req0Valid = 0;
    cyc();
    checks++; if (rsp0Valid !== 1'b1 || rspResult !== 32'h00FFF0FF) begin fails++; $display("FAIL abort_next: got %b %h want 1 00fff0ff", rsp0Valid, rspResult); end
    rsp0Ready = 1;
    cyc();
    clear_inputs();
  endtask

  initial begin
    nReset = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_back_pressure();
    test_ops();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
